// File: rtl/mem_access_seq_if.sv
// Data-memory bus between the memory-stage sequencer and the single-ported
// data memory. The master drives the request, the slave answers with ack/data.
interface mem_access_seq_if;
   logic        memReq;
   logic        memWr;
   logic [15:0] memAddr;
   logic [15:0] memWrData;
   logic        memAck;
   logic [15:0] memRdData;

   modport master (
      output memReq, memWr, memAddr, memWrData,
      input  memAck, memRdData
   );

   modport slave (
      input  memReq, memWr, memAddr, memWrData,
      output memAck, memRdData
   );
endinterface

// File: rtl/mem_access_seq.sv
// Memory-stage sequencer: runs one LOAD, STORE or SWAP transaction on the
// data-memory bus, stalls the pipeline while it is in flight, returns read
// data to write-back and aborts with a fault pulse when the bus never acks.
module mem_access_seq #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_start,
   input  logic              i_isMemInstr,
   input  logic              i_isMemWriter,
   input  logic              i_isSWP,
   input  logic [15:0]       i_addr,
   input  logic [15:0]       i_wrData,
   mem_access_seq_if.master  bus,
   output logic              o_stall,
   output logic              o_rdValid,
   output logic [15:0]       o_rdData,
   output logic              o_fault
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
   typedef enum logic [1:0] {T_LOAD, T_STORE, T_SWAP} xfer_t;

   // Last waiting cycle before abort: the count would reach the limit on it.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   xfer_t       type_q, type_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        wr_q, wr_d;
   logic        rdvalid_q, rdvalid_d;
   logic        fault_q, fault_d;
   logic        accept_s;

   // Accept a new memory instruction only when no transaction is in flight.
   always_comb begin
      accept_s = i_start & i_isMemInstr &
                 ((state_q == S_IDLE) | (state_q == S_DONE));
   end

   // Next-state, latches, timeout and registered-output decode.
   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      rdvalid_d = 1'b0;
      fault_d   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            cnt_d = 8'd0;
            if (accept_s) begin
               addr_d  = i_addr;
               wdata_d = i_wrData;
               if (i_isSWP) begin
                  type_d  = T_SWAP;
                  state_d = S_READ;
               end else if (i_isMemWriter) begin
                  type_d  = T_STORE;
                  state_d = S_WRITE;
               end else begin
                  type_d  = T_LOAD;
                  state_d = S_READ;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            if (bus.memAck) begin
               rdata_d = bus.memRdData;
               cnt_d   = 8'd0;
               if (type_q == T_SWAP) begin
                  state_d = S_WRITE;
               end else begin
                  state_d   = S_DONE;
                  rdvalid_d = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               // A SWAP aborted here never reaches its write phase.
               state_d = S_IDLE;
               fault_d = 1'b1;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WRITE: begin
            if (bus.memAck) begin
               state_d   = S_DONE;
               cnt_d     = 8'd0;
               rdvalid_d = (type_q == T_SWAP);
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               fault_d = 1'b1;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
      req_d = (state_d == S_READ) | (state_d == S_WRITE);
      wr_d  = (state_d == S_WRITE);
   end

   // State, latches and registered bus/status outputs.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= S_IDLE;
         type_q    <= T_LOAD;
         addr_q    <= 16'h0000;
         wdata_q   <= 16'h0000;
         rdata_q   <= 16'h0000;
         cnt_q     <= 8'd0;
         req_q     <= 1'b0;
         wr_q      <= 1'b0;
         rdvalid_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         type_q    <= type_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         wr_q      <= wr_d;
         rdvalid_q <= rdvalid_d;
         fault_q   <= fault_d;
      end
   end

   // Drive the bus and pipeline-facing outputs.
   always_comb begin
      bus.memReq    = req_q;
      bus.memWr     = wr_q;
      bus.memAddr   = addr_q;
      bus.memWrData = wdata_q;
      o_rdValid     = rdvalid_q;
      o_rdData      = rdata_q;
      o_fault       = fault_q;
      o_stall       = (state_q == S_READ) | (state_q == S_WRITE) | accept_s;
   end

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: LOAD, delayed STORE, SWAP, back-to-back,
// timeout abort and asynchronous reset, each with hand-computed expectations.
module tb_mem_access_seq;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        is_mem = 1'b0;
   logic        is_wr = 1'b0;
   logic        is_swp = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [15:0] wdata = 16'h0000;
   logic        stall, rd_valid, fault;
   logic [15:0] rd_data;
   int          n_vec = 0;
   int          n_err = 0;

   mem_access_seq_if bus ();

   mem_access_seq #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .i_start       (start),
      .i_isMemInstr  (is_mem),
      .i_isMemWriter (is_wr),
      .i_isSWP       (is_swp),
      .i_addr        (addr),
      .i_wrData      (wdata),
      .bus           (bus.master),
      .o_stall       (stall),
      .o_rdValid     (rd_valid),
      .o_rdData      (rd_data),
      .o_fault       (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic swp, input logic [15:0] a, input logic [15:0] d);
      start  = 1'b1;
      is_mem = 1'b1;
      is_wr  = wr;
      is_swp = swp;
      addr   = a;
      wdata  = d;
   endtask

   task automatic no_issue();
      start  = 1'b0;
      is_mem = 1'b0;
      is_wr  = 1'b0;
      is_swp = 1'b0;
   endtask

   initial begin
      bus.memAck    = 1'b0;
      bus.memRdData = 16'h0000;
      #12;
      chk("rst_req",    {15'd0, bus.memReq}, 16'd0);
      chk("rst_wr",     {15'd0, bus.memWr},  16'd0);
      chk("rst_addr",   bus.memAddr,   16'h0000);
      chk("rst_wdata",  bus.memWrData, 16'h0000);
      chk("rst_rddata", rd_data,       16'h0000);
      chk("rst_stall",  {15'd0, stall},    16'd0);
      chk("rst_rdv",    {15'd0, rd_valid}, 16'd0);
      chk("rst_fault",  {15'd0, fault},    16'd0);
      @(negedge clk);
      rstn = 1'b1;

      // LOAD, immediate ack
      next_cyc(); issue(1'b0, 1'b0, 16'h1234, 16'h0000); #1;
      chk("ld_c0_stall", {15'd0, stall}, 16'd1);
      chk("ld_c0_req",   {15'd0, bus.memReq}, 16'd0);
      next_cyc(); no_issue(); bus.memAck = 1'b1; bus.memRdData = 16'hBEEF; #1;
      chk("ld_c1_req",   {15'd0, bus.memReq}, 16'd1);
      chk("ld_c1_wr",    {15'd0, bus.memWr},  16'd0);
      chk("ld_c1_addr",  bus.memAddr, 16'h1234);
      chk("ld_c1_stall", {15'd0, stall}, 16'd1);
      next_cyc(); bus.memAck = 1'b0; #1;
      chk("ld_c2_rdv",   {15'd0, rd_valid}, 16'd1);
      chk("ld_c2_data",  rd_data, 16'hBEEF);
      chk("ld_c2_stall", {15'd0, stall}, 16'd0);
      chk("ld_c2_req",   {15'd0, bus.memReq}, 16'd0);
      next_cyc(); #1;
      chk("ld_c3_rdv",   {15'd0, rd_valid}, 16'd0);

      // STORE, ack on the fourth request cycle (same cycle as timeout limit)
      next_cyc(); issue(1'b1, 1'b0, 16'h00F0, 16'h5A5A); #1;
      chk("st_c0_stall", {15'd0, stall}, 16'd1);
      for (int c = 1; c <= 4; c++) begin
         next_cyc(); no_issue(); bus.memAck = (c == 4); #1;
         chk("st_req",   {15'd0, bus.memReq}, 16'd1);
         chk("st_wr",    {15'd0, bus.memWr},  16'd1);
         chk("st_addr",  bus.memAddr,   16'h00F0);
         chk("st_wdata", bus.memWrData, 16'h5A5A);
         chk("st_stall", {15'd0, stall}, 16'd1);
      end
      next_cyc(); bus.memAck = 1'b0; #1;
      chk("st_c5_req",   {15'd0, bus.memReq}, 16'd0);
      chk("st_c5_stall", {15'd0, stall}, 16'd0);
      chk("st_c5_rdv",   {15'd0, rd_valid}, 16'd0);
      chk("st_c5_fault", {15'd0, fault}, 16'd0);
      chk("st_c5_hold",  rd_data, 16'hBEEF);

      // SWAP: read 0x2222 then write 0x1111 to 0x0040
      next_cyc(); issue(1'b0, 1'b1, 16'h0040, 16'h1111); #1;
      next_cyc(); no_issue(); bus.memAck = 1'b1; bus.memRdData = 16'h2222; #1;
      chk("sw_c1_req",  {15'd0, bus.memReq}, 16'd1);
      chk("sw_c1_wr",   {15'd0, bus.memWr},  16'd0);
      chk("sw_c1_addr", bus.memAddr, 16'h0040);
      next_cyc(); bus.memRdData = 16'hDEAD; #1;
      chk("sw_c2_req",   {15'd0, bus.memReq}, 16'd1);
      chk("sw_c2_wr",    {15'd0, bus.memWr},  16'd1);
      chk("sw_c2_addr",  bus.memAddr,   16'h0040);
      chk("sw_c2_wdata", bus.memWrData, 16'h1111);
      chk("sw_c2_rdv",   {15'd0, rd_valid}, 16'd0);
      next_cyc(); bus.memAck = 1'b0; #1;
      chk("sw_c3_rdv",   {15'd0, rd_valid}, 16'd1);
      chk("sw_c3_data",  rd_data, 16'h2222);
      chk("sw_c3_req",   {15'd0, bus.memReq}, 16'd0);
      chk("sw_c3_stall", {15'd0, stall}, 16'd0);

      // Back-to-back: STORE accepted in LOAD's DONE cycle
      next_cyc(); issue(1'b0, 1'b0, 16'h0100, 16'h0000); #1;
      next_cyc(); no_issue(); bus.memAck = 1'b1; bus.memRdData = 16'h3C3C; #1;
      chk("bb_c1_req", {15'd0, bus.memReq}, 16'd1);
      chk("bb_c1_wr",  {15'd0, bus.memWr},  16'd0);
      next_cyc(); bus.memAck = 1'b0; issue(1'b1, 1'b0, 16'h0200, 16'hA5A5); #1;
      chk("bb_c2_req",   {15'd0, bus.memReq}, 16'd0);
      chk("bb_c2_rdv",   {15'd0, rd_valid}, 16'd1);
      chk("bb_c2_data",  rd_data, 16'h3C3C);
      chk("bb_c2_stall", {15'd0, stall}, 16'd1);
      next_cyc(); no_issue(); bus.memAck = 1'b1; #1;
      chk("bb_c3_req",   {15'd0, bus.memReq}, 16'd1);
      chk("bb_c3_wr",    {15'd0, bus.memWr},  16'd1);
      chk("bb_c3_addr",  bus.memAddr,   16'h0200);
      chk("bb_c3_wdata", bus.memWrData, 16'hA5A5);
      next_cyc(); bus.memAck = 1'b0; #1;
      chk("bb_c4_req",   {15'd0, bus.memReq}, 16'd0);
      chk("bb_c4_rdv",   {15'd0, rd_valid}, 16'd0);
      chk("bb_c4_stall", {15'd0, stall}, 16'd0);

      // Timeout on SWAP, never acked
      next_cyc(); issue(1'b0, 1'b1, 16'h0080, 16'h7777); #1;
      for (int c = 1; c <= 4; c++) begin
         next_cyc(); no_issue(); #1;
         chk("to_req",   {15'd0, bus.memReq}, 16'd1);
         chk("to_wr",    {15'd0, bus.memWr},  16'd0);
         chk("to_fault", {15'd0, fault}, 16'd0);
      end
      next_cyc(); #1;
      chk("to_c5_req",   {15'd0, bus.memReq}, 16'd0);
      chk("to_c5_fault", {15'd0, fault}, 16'd1);
      chk("to_c5_stall", {15'd0, stall}, 16'd0);
      chk("to_c5_rdv",   {15'd0, rd_valid}, 16'd0);
      next_cyc(); #1;
      chk("to_c6_fault", {15'd0, fault}, 16'd0);
      chk("to_c6_req",   {15'd0, bus.memReq}, 16'd0);
      chk("to_c6_wr",    {15'd0, bus.memWr}, 16'd0);
      chk("to_c6_stall", {15'd0, stall}, 16'd0);
      chk("to_c6_hold",  rd_data, 16'h3C3C);

      // Asynchronous reset while a write request is outstanding
      next_cyc(); issue(1'b1, 1'b0, 16'h0300, 16'hFFFF); #1;
      next_cyc(); no_issue(); #1;
      chk("ar_pre_req", {15'd0, bus.memReq}, 16'd1);
      chk("ar_pre_wr",  {15'd0, bus.memWr},  16'd1);
      #1;
      rstn = 1'b0;
      #1;
      chk("ar_req",    {15'd0, bus.memReq}, 16'd0);
      chk("ar_wr",     {15'd0, bus.memWr},  16'd0);
      chk("ar_addr",   bus.memAddr,   16'h0000);
      chk("ar_wdata",  bus.memWrData, 16'h0000);
      chk("ar_rddata", rd_data, 16'h0000);
      chk("ar_stall",  {15'd0, stall}, 16'd0);
      chk("ar_rdv",    {15'd0, rd_valid}, 16'd0);
      chk("ar_fault",  {15'd0, fault}, 16'd0);
      next_cyc();
      @(negedge clk);
      rstn = 1'b1;
      next_cyc(); start = 1'b1; is_mem = 1'b0; addr = 16'h0500; #1;
      chk("nm_c0_stall", {15'd0, stall}, 16'd0);
      next_cyc(); no_issue(); #1;
      chk("nm_c1_req",   {15'd0, bus.memReq}, 16'd0);
      chk("nm_c1_stall", {15'd0, stall}, 16'd0);
      next_cyc(); #1;
      chk("nm_c2_req",   {15'd0, bus.memReq}, 16'd0);
      chk("nm_c2_rdv",   {15'd0, rd_valid}, 16'd0);
      chk("nm_c2_fault", {15'd0, fault}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
